// File: rtl/countdown_sequencer_pkg.sv
// Shared types and defaults for the countdown sequencer.
package countdown_sequencer_pkg;

  // Default counter width.
  localparam int unsigned CNT_W = 4;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/countdown_sequencer_if.sv
// Controller <-> sequencer handshake bundle.
interface countdown_sequencer_if
  import countdown_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
);

  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             last;
  logic             done;

  // Controller side.
  modport master (
    output start, load_val, en, abort,
    input  q, busy, last, done
  );

  // Sequencer side.
  modport slave (
    input  start, load_val, en, abort,
    output q, busy, last, done
  );

endinterface

// File: rtl/countdown_sequencer_down_counter.sv
// Loadable down counter built as a T-flip-flop ripple-borrow chain.
module down_counter
  import countdown_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] tog;

  // Bit i toggles when every lower bit is 0 (borrow ripples up); bit 0 always toggles.
  always_comb begin
    tog = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      tog[i] = ~|(q & WIDTH'((64'd1 << i) - 64'd1));
    end
  end

  // Parallel load has priority over the enabled decrement.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= q ^ tog;
    end
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Loadable down-counting sequencer for multi-cycle operations.
module countdown_sequencer
  import countdown_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH       = CNT_W,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic                 clk,
  input  logic                 clr_n,
  countdown_sequencer_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] q;
  logic             at_one;
  logic             cnt_load;
  logic             cnt_dec;
  logic [WIDTH-1:0] cnt_d;

  assign at_one = (q == ONE);

  // Counter control: load a new run, clear on abort, or step down on enable.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_d    = '0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          cnt_load = 1'b1;
          cnt_d    = bus.load_val;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          cnt_load = 1'b1;
        end else if (bus.en) begin
          if (AUTO_RELOAD && at_one) begin
            cnt_load = 1'b1;
            cnt_d    = bus.load_val;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (bus.abort) begin
          cnt_load = 1'b1;
        end else if (bus.start) begin
          cnt_load = 1'b1;
          cnt_d    = bus.load_val;
        end
      end
      default: begin
        cnt_load = 1'b1;
      end
    endcase
  end

  down_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .clr_n (clr_n),
    .load  (cnt_load),
    .en    (cnt_dec),
    .d     (cnt_d),
    .q     (q)
  );

  // Sequencer FSM with registered busy/done.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= ST_IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state  <= ST_RUN;
            busy_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
          end else if (bus.en && at_one) begin
            done_r <= 1'b1;
            if (!AUTO_RELOAD) begin
              state  <= ST_DONE;
              busy_r <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
          end else if (bus.start) begin
            state  <= ST_RUN;
            busy_r <= 1'b1;
          end else begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Final enabled step is flagged combinationally in the same cycle.
  assign bus.last = (state == ST_RUN) & bus.en & at_one;
  assign bus.q    = q;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Self-checking bench: plain and auto-reload sequencers driven in lockstep.
module tb_countdown_sequencer;

  localparam int unsigned W   = 4;
  localparam int          MOD = 1 << W;

  logic clk;
  logic clr_n;

  countdown_sequencer_if #(.WIDTH(W)) bus0 ();
  countdown_sequencer_if #(.WIDTH(W)) bus1 ();

  countdown_sequencer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus0)
  );

  countdown_sequencer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut_ar (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus1)
  );

  int checks = 0;
  int errors = 0;

  // Reference: steps left in the run, plus run/done flags, per instance.
  int m_left [2];
  bit m_busy [2];
  bit m_done [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int run_len(input int lv);
    return (lv == 0) ? MOD : lv;
  endfunction

  function automatic logic [W-1:0] get_q(input int i);
    return (i == 0) ? bus0.q : bus1.q;
  endfunction

  function automatic logic get_busy(input int i);
    return (i == 0) ? bus0.busy : bus1.busy;
  endfunction

  function automatic logic get_done(input int i);
    return (i == 0) ? bus0.done : bus1.done;
  endfunction

  function automatic logic get_last(input int i);
    return (i == 0) ? bus0.last : bus1.last;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0;
      m_busy[i] = 1'b0;
      m_done[i] = 1'b0;
    end
  endtask

  task automatic drive(input bit s, input int lv, input bit e, input bit a);
    bus0.start = s;  bus0.load_val = W'(lv);  bus0.en = e;  bus0.abort = a;
    bus1.start = s;  bus1.load_val = W'(lv);  bus1.en = e;  bus1.abort = a;
  endtask

  // One clock: drive at negedge, check last, advance the model, check registered outputs.
  task automatic step(input bit s, input int lv, input bit e, input bit a);
    logic [W-1:0] exp_q;
    logic         exp_last;
    drive(s, lv, e, a);
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_last = m_busy[i] && e && (m_left[i] == 1);
      checks++;
      if (get_last(i) !== exp_last) begin
        errors++;
        $display("FAIL last[%0d] t=%0t: got %b expected %b", i, $time, get_last(i), exp_last);
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (m_busy[i]) begin
        if (a) begin
          m_busy[i] = 1'b0; m_done[i] = 1'b0; m_left[i] = 0;
        end else if (e) begin
          m_left[i] = m_left[i] - 1;
          m_done[i] = (m_left[i] == 0);
          if (m_left[i] == 0) begin
            if (i == 1) m_left[i] = run_len(lv);
            else        m_busy[i] = 1'b0;
          end
        end else begin
          m_done[i] = 1'b0;
        end
      end else if (m_done[i]) begin
        m_done[i] = 1'b0;
        if (a) begin
          m_left[i] = 0;
        end else if (s) begin
          m_busy[i] = 1'b1; m_left[i] = run_len(lv);
        end
      end else if (s) begin
        m_busy[i] = 1'b1; m_left[i] = run_len(lv);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      exp_q = W'(m_left[i] % MOD);
      checks++;
      if (get_q(i) !== exp_q || get_busy(i) !== m_busy[i] || get_done(i) !== m_done[i]) begin
        errors++;
        $display("FAIL outputs[%0d] t=%0t: got q=%0d busy=%b done=%b expected q=%0d busy=%b done=%b",
                 i, $time, get_q(i), get_busy(i), get_done(i), exp_q, m_busy[i], m_done[i]);
      end
    end
  endtask

  task automatic abort_all();
    step(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    model_reset();
    drive(1'b0, 0, 1'b0, 1'b0);
    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (get_q(i) !== '0 || get_busy(i) !== 1'b0 || get_done(i) !== 1'b0 || get_last(i) !== 1'b0) begin
        errors++;
        $display("FAIL reset_init[%0d]: got q=%0d busy=%b done=%b last=%b expected all 0",
                 i, get_q(i), get_busy(i), get_done(i), get_last(i));
      end
    end
    clr_n = 1'b1;
    step(1'b1, 9, 1'b1, 1'b0);
    repeat (3) step(1'b0, 9, 1'b1, 1'b0);
    // Asynchronous clear between edges while both instances run.
    #2 clr_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (get_q(i) !== '0 || get_busy(i) !== 1'b0 || get_done(i) !== 1'b0 || get_last(i) !== 1'b0) begin
        errors++;
        $display("FAIL reset_midrun[%0d]: got q=%0d busy=%b done=%b last=%b expected all 0",
                 i, get_q(i), get_busy(i), get_done(i), get_last(i));
      end
    end
    model_reset();
    @(negedge clk);
    clr_n = 1'b1;
    repeat (3) step(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_basic();
    step(1'b1, 5, 1'b1, 1'b0);
    checks++;
    if (bus0.q !== 4'd5 || bus0.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_load: got q=%0d busy=%b expected q=5 busy=1", bus0.q, bus0.busy);
    end
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 5, 1'b1, 1'b0);
      checks++;
      if (bus0.q !== W'(5 - k) || bus0.busy !== (k < 5) || bus0.done !== (k == 5)) begin
        errors++;
        $display("FAIL basic_step%0d: got q=%0d busy=%b done=%b expected q=%0d busy=%b done=%b",
                 k, bus0.q, bus0.busy, bus0.done, 5 - k, k < 5, k == 5);
      end
    end
    step(1'b0, 5, 1'b1, 1'b0);
    checks++;
    if (bus0.done !== 1'b0 || bus0.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: got busy=%b done=%b expected 0 0", bus0.busy, bus0.done);
    end
    abort_all();
  endtask

  task automatic test_wrap();
    int busy_cycles;
    step(1'b1, 0, 1'b1, 1'b0);
    busy_cycles = bus0.busy ? 1 : 0;
    checks++;
    if (bus0.q !== 4'd0) begin
      errors++;
      $display("FAIL wrap_load: got q=%0d expected 0", bus0.q);
    end
    step(1'b0, 0, 1'b1, 1'b0);
    if (bus0.busy) busy_cycles++;
    checks++;
    if (bus0.q !== 4'd15) begin
      errors++;
      $display("FAIL wrap_first: got q=%0d expected 15", bus0.q);
    end
    for (int k = 0; k < 40 && bus0.busy; k++) begin
      step(1'b0, 0, 1'b1, 1'b0);
      if (bus0.busy) busy_cycles++;
    end
    checks++;
    if (busy_cycles != 16 || bus0.done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_len: got %0d busy cycles done=%b expected 16 done=1", busy_cycles, bus0.done);
    end
    abort_all();
  endtask

  task automatic test_gated_enable();
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int qexp [6] = '{2, 2, 2, 1, 1, 0};
    step(1'b1, 3, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 3, pat[k], 1'b0);
      checks++;
      if (bus0.q !== W'(qexp[k]) || bus0.done !== (k == 5)) begin
        errors++;
        $display("FAIL gated_step%0d: got q=%0d done=%b expected q=%0d done=%b",
                 k, bus0.q, bus0.done, qexp[k], k == 5);
      end
    end
    abort_all();
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b0, 1, 1'b1, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0);
    checks++;
    if (bus0.busy !== 1'b1 || bus0.q !== 4'd2 || bus0.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reload: got q=%0d busy=%b done=%b expected q=2 busy=1 done=0",
               bus0.q, bus0.busy, bus0.done);
    end
    step(1'b1, 7, 1'b0, 1'b0);
    checks++;
    if (bus0.q !== 4'd2 || bus0.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_in_run: got q=%0d busy=%b expected q=2 busy=1", bus0.q, bus0.busy);
    end
    repeat (3) step(1'b0, 0, 1'b1, 1'b0);
    abort_all();
    step(1'b1, 3, 1'b0, 1'b0);
    step(1'b1, 5, 1'b1, 1'b1);
    checks++;
    if (bus0.q !== 4'd0 || bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_start: got q=%0d busy=%b done=%b expected q=0 busy=0 done=0",
               bus0.q, bus0.busy, bus0.done);
    end
    step(1'b0, 0, 1'b1, 1'b0);
    abort_all();
  endtask

  task automatic test_auto_reload();
    logic [W-1:0] eq;
    step(1'b1, 2, 1'b1, 1'b0);
    checks++;
    if (bus1.q !== 4'd2 || bus1.busy !== 1'b1) begin
      errors++;
      $display("FAIL ar_load: got q=%0d busy=%b expected q=2 busy=1", bus1.q, bus1.busy);
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 2, 1'b1, 1'b0);
      eq = (k % 2 == 0) ? 4'd1 : 4'd2;
      checks++;
      if (bus1.q !== eq || bus1.busy !== 1'b1 || bus1.done !== (k % 2 == 1)) begin
        errors++;
        $display("FAIL ar_step%0d: got q=%0d busy=%b done=%b expected q=%0d busy=1 done=%b",
                 k, bus1.q, bus1.busy, bus1.done, eq, k % 2 == 1);
      end
    end
    step(1'b0, 2, 1'b1, 1'b1);
    checks++;
    if (bus1.q !== 4'd0 || bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
      errors++;
      $display("FAIL ar_abort: got q=%0d busy=%b done=%b expected q=0 busy=0 done=0",
               bus1.q, bus1.busy, bus1.done);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) == 0, int'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
    end
    abort_all();
  endtask

  initial begin
    clr_n = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0);
    test_reset();
    test_basic();
    test_wrap();
    test_gated_enable();
    test_back_to_back();
    test_auto_reload();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
